// File: rtl/sort_pkt_arbiter.sv
// sort_pkt_arbiter: packet-level round-robin arbiter sharing one sort engine between NUM_SRC Avalon-ST sources.
// Latency: grant registered one cycle after an SOP is seen in IDLE; the PASS data path is combinational (zero latency).
// Backpressure: granted source's ready mirrors src_ready_i; the next grant waits for done_i from the sorter.
//
// Ports:
//   clk_i, arstn_i                     clock, asynchronous active-low reset
//   snk_*_i / snk_ready_o              NUM_SRC packed Avalon-ST sinks (source k at [k*DWIDTH +: DWIDTH])
//   src_*_o / src_ready_i              single Avalon-ST stream towards the sorter
//   done_i                             sorter finished emitting the sorted packet
//   grant_id_o, busy_o, trunc_o        status: current/last owner, not-IDLE, truncation pulse
//   stat_pkt_cnt_o                     per-source 16-bit packet counters (source k at [k*16 +: 16])
// Optional feature: define SORT_ARB_STATS_EN to build the packet counters; otherwise stat_pkt_cnt_o is 0.
module sort_pkt_arbiter #(
  parameter  int DWIDTH      = 8,
  parameter  int NUM_SRC     = 4,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int SRC_W       = $clog2(NUM_SRC),
  localparam int CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic [NUM_SRC*DWIDTH-1:0] snk_data_i,
  input  logic [NUM_SRC-1:0]        snk_startofpacket_i,
  input  logic [NUM_SRC-1:0]        snk_endofpacket_i,
  input  logic [NUM_SRC-1:0]        snk_valid_i,
  output logic [NUM_SRC-1:0]        snk_ready_o,
  output logic [DWIDTH-1:0]         src_data_o,
  output logic                      src_startofpacket_o,
  output logic                      src_endofpacket_o,
  output logic                      src_valid_o,
  input  logic                      src_ready_i,
  input  logic                      done_i,
  output logic [SRC_W-1:0]          grant_id_o,
  output logic                      busy_o,
  output logic                      trunc_o,
  output logic [NUM_SRC*16-1:0]     stat_pkt_cnt_o
);

  localparam int IDX_W = SRC_W + 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP, WAIT_DONE} state_t;

  state_t            state;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  ptr;
  logic [CNT_W-1:0]  wcnt;
  logic              trunc_q;

  logic [DWIDTH-1:0] g_data;
  logic              g_sop;
  logic              g_eop;
  logic              g_vld;
  logic              last_word;
  logic              xfer;

  logic [NUM_SRC-1:0] cand;
  logic               win_found;
  logic [SRC_W-1:0]   win_id;
  logic [IDX_W-1:0]   idx;

  // Granted source's lanes.
  assign g_data = snk_data_i[int'(grant)*DWIDTH +: DWIDTH];
  assign g_sop  = snk_startofpacket_i[grant];
  assign g_eop  = snk_endofpacket_i[grant];
  assign g_vld  = snk_valid_i[grant];

  // The word about to transfer is word number MAX_PKT_LEN of the packet.
  assign last_word = (wcnt == CNT_W'(MAX_PKT_LEN - 1));
  assign xfer      = (state == PASS) && g_vld && src_ready_i;

  assign cand = snk_valid_i & snk_startofpacket_i;

  // Round-robin search starting at ptr. Walking downward and overwriting
  // leaves the candidate closest to ptr (in wrap order) as the winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_SRC)) idx = idx - IDX_W'(NUM_SRC);
      if (cand[idx[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    snk_ready_o         = '0;
    src_valid_o         = 1'b0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    case (state)
      // Stray mid-packet words (valid without SOP) are flushed while idle.
      IDLE: snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
      PASS: begin
        snk_ready_o[grant]  = src_ready_i;
        src_valid_o         = g_vld;
        src_startofpacket_o = g_sop & (wcnt == '0);
        src_endofpacket_o   = g_eop | last_word;
      end
      DROP:    snk_ready_o[grant] = 1'b1;
      default: ;
    endcase
    // Reset is visible on the handshake immediately, not at the next edge,
    // so the idle flush cannot swallow words while reset is held.
    if (!arstn_i) snk_ready_o = '0;
  end

  assign src_data_o = g_data;
  assign grant_id_o = grant;
  assign busy_o     = (state != IDLE);
  assign trunc_o    = trunc_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      wcnt    <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_id;
            wcnt  <= '0;
            state <= PASS;
          end
        end
        PASS: begin
          if (xfer) begin
            wcnt <= wcnt + CNT_W'(1);
            if (g_eop) begin
              state <= WAIT_DONE;
            end else if (last_word) begin
              state   <= DROP;
              trunc_q <= 1'b1;
            end
          end
        end
        DROP: begin
          if (g_vld && g_eop) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_i) begin
            ptr   <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SORT_ARB_STATS_EN
  logic                  enter_wait;
  logic [NUM_SRC*16-1:0] stat_q;

  assign enter_wait = (xfer && g_eop) || ((state == DROP) && g_vld && g_eop);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stat_q <= '0;
    end else if (enter_wait) begin
      stat_q[int'(grant)*16 +: 16] <= stat_q[int'(grant)*16 +: 16] + 16'd1;
    end
  end

  assign stat_pkt_cnt_o = stat_q;
`else
  assign stat_pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// tb_sort_pkt_arbiter: directed and randomized stimulus against a transaction-level model of the arbiter.
// Latency: sources and sorter are driven after each negedge; DUT outputs are sampled 1 ns later.
// Backpressure: src_ready_i is fixed, toggled or random depending on the step.
module tb_sort_pkt_arbiter;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int MAXL = 5;
`ifdef SORT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef enum {M_IDLE, M_BUSY, M_WAIT} mphase_t;
  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } word_t;

  logic              clk = 1'b0;
  logic              arstn = 1'b1;
  logic [N*DW-1:0]   snk_data;
  logic [N-1:0]      snk_sop;
  logic [N-1:0]      snk_eop;
  logic [N-1:0]      snk_valid;
  logic [N-1:0]      snk_ready;
  logic [DW-1:0]     src_data;
  logic              src_sop;
  logic              src_eop;
  logic              src_valid;
  logic              src_ready;
  logic              done;
  logic [1:0]        grant_id;
  logic              busy;
  logic              trunc;
  logic [N*16-1:0]   stat;

  sort_pkt_arbiter #(.DWIDTH(DW), .NUM_SRC(N), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
    .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
    .src_data_o(src_data), .src_startofpacket_o(src_sop), .src_endofpacket_o(src_eop),
    .src_valid_o(src_valid), .src_ready_i(src_ready), .done_i(done),
    .grant_id_o(grant_id), .busy_o(busy), .trunc_o(trunc), .stat_pkt_cnt_o(stat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Source-side packet state.
  int         pkt_len [N];
  logic [7:0] pkt_dat [N][16];
  int         widx    [N];
  bit         pending [N];

  // Reference model.
  mphase_t     m_phase;
  int          m_ptr;
  int          m_g;
  word_t       exp_q[$];
  bit          m_trunc_pkt;
  bit          exp_trunc;
  logic [15:0] m_stat [N];
  bit          just_granted;

  // Observations of the DUT.
  int out_cnt;
  int trunc_seen;
  int dut_grants[$];

  // Stimulus controls.
  int ready_mode;   // 0: fixed 1, 1: toggle 1,0,..., 2: random
  int gen_mode;     // 0: none, 1: reload immediately, 2: random arrivals
  int spur_mode;    // 0: none, 1: random done outside WAIT, 2: done held high while busy
  bit rnd_gap;
  bit auto_done;
  bit done_force;
  bit tog;

  int dir_dat[5]   = '{10, 3, 7, 1, 9};
  int exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_pkt(input int k, input int len);
    pkt_len[k] = len;
    for (int i = 0; i < len; i++) pkt_dat[k][i] = 8'($urandom);
    widx[k]    = 0;
    pending[k] = 1'b1;
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int k = 0; k < N; k++) p |= pending[k];
    return p;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (!pending[k] && (gen_mode == 1 || (gen_mode == 2 && $urandom_range(0, 3) == 0)))
        new_pkt(k, $urandom_range(1, 8));
      if (pending[k] && !(rnd_gap && $urandom_range(0, 3) == 0)) begin
        snk_valid[k]          = 1'b1;
        snk_data[k*DW +: DW]  = pkt_dat[k][widx[k]];
        snk_sop[k]            = (widx[k] == 0);
        snk_eop[k]            = (widx[k] == pkt_len[k] - 1);
      end else begin
        snk_valid[k]          = 1'b0;
        snk_sop[k]            = 1'b0;
        snk_eop[k]            = 1'b0;
        snk_data[k*DW +: DW]  = DW'($urandom);
      end
    end
    case (ready_mode)
      0:       src_ready = 1'b1;
      1:       begin src_ready = tog; tog = !tog; end
      default: src_ready = 1'($urandom_range(0, 1));
    endcase
    done = done_force
        || (auto_done && m_phase == M_WAIT && $urandom_range(0, 1) == 1)
        || (spur_mode == 1 && m_phase != M_WAIT && $urandom_range(0, 3) == 0)
        || (spur_mode == 2 && m_phase == M_BUSY);
  endtask

  // Checks the current cycle against the model and advances the model to
  // what the coming clock edge must produce.
  task automatic sample();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] cand;
    bit           exp_sv;
    int           win;
    int           kk;
    int           n;
    word_t        w;

    chk("busy", busy, (m_phase != M_IDLE));
    chk("grant_id", grant_id, m_g);
    chk("trunc", trunc, exp_trunc);
    for (int k = 0; k < N; k++) chk("stat", stat[k*16 +: 16], STATS ? m_stat[k] : 16'd0);
    exp_trunc = 1'b0;
    if (trunc) trunc_seen++;
    if (just_granted) begin
      dut_grants.push_back(int'(grant_id));
      just_granted = 1'b0;
    end

    case (m_phase)
      M_IDLE: begin
        chk("ready_idle", snk_ready, snk_valid & ~snk_sop);
        chk("valid_idle", src_valid, 0);
        cand = snk_valid & snk_sop;
        win  = -1;
        for (int i = 0; i < N; i++) begin
          kk = (m_ptr + i) % N;
          if (win < 0 && cand[kk]) win = kk;
        end
        if (win >= 0) begin
          m_g = win;
          n   = (pkt_len[win] < MAXL) ? pkt_len[win] : MAXL;
          exp_q.delete();
          for (int i = 0; i < n; i++) begin
            w.d   = pkt_dat[win][i];
            w.sop = (i == 0);
            w.eop = (i == n - 1);
            exp_q.push_back(w);
          end
          m_trunc_pkt  = (pkt_len[win] > MAXL);
          m_phase      = M_BUSY;
          just_granted = 1'b1;
        end
      end
      M_BUSY: begin
        exp_rdy = '0;
        if (exp_q.size() > 0) begin
          exp_rdy[m_g] = src_ready;
          exp_sv       = snk_valid[m_g];
        end else begin
          exp_rdy[m_g] = 1'b1;
          exp_sv       = 1'b0;
        end
        chk("ready_busy", snk_ready, exp_rdy);
        chk("valid_busy", src_valid, exp_sv);
        if (src_valid && src_ready && exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("out_data", src_data, w.d);
          chk("out_sop", src_sop, w.sop);
          chk("out_eop", src_eop, w.eop);
          out_cnt++;
          if (exp_q.size() == 0 && m_trunc_pkt) exp_trunc = 1'b1;
        end
        if (snk_valid[m_g] && snk_ready[m_g] && snk_eop[m_g]) begin
          chk("pkt_drained", exp_q.size(), 0);
          m_phase = M_WAIT;
          m_stat[m_g] = m_stat[m_g] + 16'd1;
        end
      end
      default: begin
        chk("ready_wait", snk_ready, 0);
        chk("valid_wait", src_valid, 0);
        if (done) begin
          m_ptr   = (m_g + 1) % N;
          m_phase = M_IDLE;
        end
      end
    endcase

    for (int k = 0; k < N; k++) begin
      if (snk_valid[k] && snk_ready[k]) begin
        widx[k]++;
        if (widx[k] == pkt_len[k]) pending[k] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(m_phase == M_IDLE && !any_pending()) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, (n < budget), 1);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", snk_ready, 0);
    chk("rst_valid", src_valid, 0);
    chk("rst_sop", src_sop, 0);
    chk("rst_eop", src_eop, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_trunc", trunc, 0);
    for (int k = 0; k < N; k++) chk("rst_stat", stat[k*16 +: 16], 0);
    m_phase      = M_IDLE;
    m_ptr        = 0;
    m_g          = 0;
    exp_q.delete();
    exp_trunc    = 1'b0;
    just_granted = 1'b0;
    for (int k = 0; k < N; k++) m_stat[k] = '0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  initial begin
    int n;
    snk_data = '0; snk_sop = '0; snk_eop = '0; snk_valid = '0;
    src_ready = 1'b0; done = 1'b0;
    for (int k = 0; k < N; k++) begin pending[k] = 1'b0; widx[k] = 0; pkt_len[k] = 1; end
    ready_mode = 0; gen_mode = 0; spur_mode = 0;
    rnd_gap = 1'b0; auto_done = 1'b0; done_force = 1'b0; tog = 1'b1;
    out_cnt = 0; trunc_seen = 0;

    #2;
    do_reset();

    // Single source, 5 words (exactly MAX_PKT_LEN, so not truncated).
    pkt_len[1] = 5;
    for (int i = 0; i < 5; i++) pkt_dat[1][i] = 8'(dir_dat[i]);
    widx[1] = 0; pending[1] = 1'b1;
    out_cnt = 0; trunc_seen = 0; dut_grants.delete();
    n = 0;
    while (m_phase != M_WAIT && n < 30) begin cycle(); n++; end
    chk("t1_reach_wait", (m_phase == M_WAIT), 1);
    chk("t1_words", out_cnt, 5);
    chk("t1_grant", grant_id, 1);
    chk("t1_busy_wait", busy, 1);
    chk("t1_no_trunc", trunc_seen, 0);
    done_force = 1'b1;
    cycle();
    done_force = 1'b0;
    chk("t1_busy_after_done", busy, 0);
    chk("t1_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 1);

    // Contention: every source always requesting.
    do_reset();
    dut_grants.delete();
    gen_mode = 1; auto_done = 1'b1;
    n = 0;
    while (dut_grants.size() < 5 && n < 500) begin cycle(); n++; end
    chk("t2_timeout", (n < 500), 1);
    for (int i = 0; i < 5; i++)
      chk("t2_order", (dut_grants.size() > i) ? dut_grants[i] : -1, exp_order[i]);
    gen_mode = 0;
    drain("t2_drain", 500);

    // Truncation, exact-length and single-word packets.
    out_cnt = 0; trunc_seen = 0;
    new_pkt(2, 7);
    drain("t3_drain_long", 100);
    chk("t3_words_long", out_cnt, MAXL);
    chk("t3_trunc_long", trunc_seen, 1);
    out_cnt = 0; trunc_seen = 0;
    new_pkt(0, MAXL);
    drain("t3_drain_exact", 100);
    chk("t3_words_exact", out_cnt, MAXL);
    chk("t3_trunc_exact", trunc_seen, 0);
    out_cnt = 0;
    new_pkt(3, 1);
    drain("t3_drain_one", 100);
    chk("t3_words_one", out_cnt, 1);

    // Backpressure: sorter ready toggles every cycle.
    ready_mode = 1; tog = 1'b1; out_cnt = 0;
    new_pkt(3, 3);
    drain("t4_drain", 100);
    chk("t4_words", out_cnt, 3);
    ready_mode = 0;

    // Done gating: done held during PASS is ignored; no grant until done.
    auto_done = 1'b0; spur_mode = 2;
    new_pkt(0, 2);
    n = 0;
    while (m_phase != M_WAIT && n < 30) begin cycle(); n++; end
    chk("t5_reach_wait", (m_phase == M_WAIT), 1);
    spur_mode = 0;
    new_pkt(3, 2);
    repeat (6) cycle();
    chk("t5_held_grant", grant_id, 0);
    chk("t5_held_busy", busy, 1);
    chk("t5_held_ready", snk_ready, 0);
    dut_grants.delete();
    done_force = 1'b1;
    cycle();
    done_force = 1'b0;
    auto_done = 1'b1;
    drain("t5_drain", 100);
    chk("t5_next_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 3);

    // Reset mid-PASS: outputs clear at once, pointer returns to 0.
    new_pkt(1, 3);
    drain("t6_pre_drain", 100);
    new_pkt(1, 5);
    out_cnt = 0;
    n = 0;
    while (out_cnt < 2 && n < 30) begin cycle(); n++; end
    chk("t6_mid_pass", busy, 1);
    do_reset();
    dut_grants.delete();
    new_pkt(0, 2);
    new_pkt(3, 2);
    drain("t6_drain", 200);
    chk("t6_ptr_zero", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);

    // Statistics: three packets from source 2.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      new_pkt(2, $urandom_range(1, 8));
      drain("t7_drain", 100);
    end
    for (int k = 0; k < N; k++)
      chk("t7_stat", stat[k*16 +: 16], (STATS && k == 2) ? 3 : 0);

    // Randomized traffic, gaps, backpressure and stray done pulses.
    rnd_gap = 1'b1; ready_mode = 2; gen_mode = 2; spur_mode = 1; auto_done = 1'b1;
    repeat (1500) cycle();
    gen_mode = 0; spur_mode = 0;
    drain("t8_drain", 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
